// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - fetch program counter with jump, call/return and circular return-address stack
module pc_unit_ras #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
  parameter int               INSTR_BYTES = 4,
  parameter int               RAS_DEPTH   = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             BUSYWAIT,
  input  logic [2:0]       PC_MODE,
  input  logic             COND,
  input  logic [WIDTH-1:0] OFFSET,
  input  logic [WIDTH-1:0] TARGET,
  output logic [WIDTH-1:0] PC_DATA,
  output logic [WIDTH-1:0] PC_PLUS,
  output logic [WIDTH-1:0] RAS_TOP,
  output logic             RAS_EMPTY,
  output logic             RAS_FULL,
  output logic             RAS_OVF,
  output logic             RAS_UNF
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  localparam logic [PW-1:0] LAST_IDX = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(RAS_DEPTH);

  localparam logic [2:0] MODE_SEQ    = 3'd0;
  localparam logic [2:0] MODE_BRANCH = 3'd1;
  localparam logic [2:0] MODE_JUMP   = 3'd2;
  localparam logic [2:0] MODE_CALL   = 3'd3;
  localparam logic [2:0] MODE_RET    = 3'd4;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    wp_q, wp_d;      // next slot to write; top entry sits one below
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    wp_inc;
  logic             push, pop;

  // Derived views of the registered stack state
  always_comb begin
    top_idx   = (wp_q == '0) ? LAST_IDX : wp_q - PW'(1);
    wp_inc    = (wp_q == LAST_IDX) ? '0 : wp_q + PW'(1);
    PC_DATA   = pc_q;
    PC_PLUS   = pc_q + WIDTH'(INSTR_BYTES);
    RAS_EMPTY = (cnt_q == '0);
    RAS_FULL  = (cnt_q == DEPTH_CNT);
    RAS_TOP   = RAS_EMPTY ? '0 : ras_q[top_idx];
    RAS_OVF   = ovf_q;
    RAS_UNF   = unf_q;
  end

  // Next PC selection and stack push/pop; a stall freezes everything
  always_comb begin
    pc_d  = pc_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    ras_d = ras_q;
    push  = 1'b0;
    pop   = 1'b0;

    if (!BUSYWAIT) begin
      case (PC_MODE)
        MODE_SEQ:    pc_d = PC_PLUS;
        MODE_BRANCH: pc_d = COND ? PC_PLUS + OFFSET : PC_PLUS;
        MODE_JUMP:   pc_d = TARGET;
        MODE_CALL: begin
          pc_d = PC_PLUS + OFFSET;
          push = 1'b1;
        end
        MODE_RET: begin
          if (RAS_EMPTY) begin
            pc_d  = PC_PLUS;
            unf_d = 1'b1;
          end else begin
            pc_d = ras_q[top_idx];
            pop  = 1'b1;
          end
        end
        default:     pc_d = PC_PLUS;
      endcase
    end

    // When full, wp already points at the oldest entry, so a push overwrites it
    if (push) begin
      ras_d[wp_q] = PC_PLUS;
      wp_d        = wp_inc;
      if (RAS_FULL) ovf_d = 1'b1;
      else          cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      wp_d  = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q  <= RESET_ADDR;
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= ras_d[i];
    end
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - directed self-checking bench for pc_unit_ras
module tb_pc_unit_ras;

  logic        CLK;
  logic        RESET_N;
  logic        BUSYWAIT;
  logic [2:0]  PC_MODE;
  logic        COND;
  logic [31:0] OFFSET;
  logic [31:0] TARGET;
  logic [31:0] PC_DATA;
  logic [31:0] PC_PLUS;
  logic [31:0] RAS_TOP;
  logic        RAS_EMPTY;
  logic        RAS_FULL;
  logic        RAS_OVF;
  logic        RAS_UNF;

  int n_checks;
  int n_errors;

  pc_unit_ras #(
    .WIDTH(32), .RESET_ADDR(32'h0), .INSTR_BYTES(4), .RAS_DEPTH(4)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .BUSYWAIT(BUSYWAIT), .PC_MODE(PC_MODE),
    .COND(COND), .OFFSET(OFFSET), .TARGET(TARGET), .PC_DATA(PC_DATA),
    .PC_PLUS(PC_PLUS), .RAS_TOP(RAS_TOP), .RAS_EMPTY(RAS_EMPTY),
    .RAS_FULL(RAS_FULL), .RAS_OVF(RAS_OVF), .RAS_UNF(RAS_UNF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [2:0] mode);
    PC_MODE = mode;
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] ret_exp [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    RESET_N  = 1'b0;
    BUSYWAIT = 1'b0;
    PC_MODE  = 3'd0;
    COND     = 1'b0;
    OFFSET   = 32'h0;
    TARGET   = 32'h0;

    // 1: reset state
    #2;
    check("rst_pc", PC_DATA, 32'h0);
    check("rst_empty", {31'b0, RAS_EMPTY}, 32'h1);
    check("rst_full", {31'b0, RAS_FULL}, 32'h0);
    check("rst_flags", {30'b0, RAS_OVF, RAS_UNF}, 32'h0);
    check("rst_top", RAS_TOP, 32'h0);
    RESET_N = 1'b1;
    step(3'd0);
    step(3'd0);
    check("pre_async_pc", PC_DATA, 32'h8);
    #3 RESET_N = 1'b0;
    #1;
    check("async_rst_pc", PC_DATA, 32'h0);
    RESET_N = 1'b1;

    // 2: sequential and stall
    step(3'd0); check("seq1", PC_DATA, 32'h4);
    step(3'd0); check("seq2", PC_DATA, 32'h8);
    step(3'd0); check("seq3", PC_DATA, 32'hC);
    check("pc_plus", PC_PLUS, 32'h10);
    BUSYWAIT = 1'b1; TARGET = 32'h200;
    step(3'd2); check("stall1", PC_DATA, 32'hC);
    step(3'd2); check("stall2", PC_DATA, 32'hC);
    BUSYWAIT = 1'b0;

    // 3: branch and jump
    OFFSET = 32'hFFFF_FFF8; COND = 1'b1;
    step(3'd1); check("br_taken", PC_DATA, 32'h8);
    COND = 1'b0;
    step(3'd1); check("br_not", PC_DATA, 32'hC);
    TARGET = 32'h100;
    step(3'd2); check("jump", PC_DATA, 32'h100);

    // 4: single call/return
    OFFSET = 32'h40;
    step(3'd3); check("call_pc", PC_DATA, 32'h144);
    check("call_top", RAS_TOP, 32'h104);
    check("call_empty", {31'b0, RAS_EMPTY}, 32'h0);
    step(3'd4); check("ret_pc", PC_DATA, 32'h104);
    check("ret_empty", {31'b0, RAS_EMPTY}, 32'h1);

    // 5: overflow then underflow
    OFFSET = 32'h10;
    step(3'd3); check("c1_pc", PC_DATA, 32'h118);
    step(3'd3); check("c2_pc", PC_DATA, 32'h12C);
    step(3'd3); check("c3_pc", PC_DATA, 32'h140);
    step(3'd3); check("c4_pc", PC_DATA, 32'h154);
    check("c4_full", {31'b0, RAS_FULL}, 32'h1);
    check("c4_ovf", {31'b0, RAS_OVF}, 32'h0);
    step(3'd3); check("c5_pc", PC_DATA, 32'h168);
    check("c5_full", {31'b0, RAS_FULL}, 32'h1);
    check("c5_ovf", {31'b0, RAS_OVF}, 32'h1);
    check("c5_top", RAS_TOP, 32'h158);
    ret_exp[0] = 32'h158; ret_exp[1] = 32'h144; ret_exp[2] = 32'h130; ret_exp[3] = 32'h11C;
    for (int i = 0; i < 4; i++) begin
      step(3'd4);
      check($sformatf("lifo_ret%0d", i), PC_DATA, ret_exp[i]);
    end
    check("lifo_empty", {31'b0, RAS_EMPTY}, 32'h1);
    check("pre_unf", {31'b0, RAS_UNF}, 32'h0);
    step(3'd4); check("unf_pc", PC_DATA, 32'h120);
    check("unf_flag", {31'b0, RAS_UNF}, 32'h1);
    BUSYWAIT = 1'b1;
    step(3'd3); check("stall_call_pc", PC_DATA, 32'h120);
    check("stall_call_empty", {31'b0, RAS_EMPTY}, 32'h1);
    BUSYWAIT = 1'b0;
    step(3'd0);
    check("sticky_flags", {30'b0, RAS_OVF, RAS_UNF}, 32'h3);

    // 6: wrap-around and reserved mode
    TARGET = 32'hFFFF_FFFC;
    step(3'd2); check("jump_hi", PC_DATA, 32'hFFFF_FFFC);
    step(3'd0); check("wrap", PC_DATA, 32'h0);
    step(3'd6); check("reserved", PC_DATA, 32'h4);
    check("reserved_empty", {31'b0, RAS_EMPTY}, 32'h1);

    // reset during a stall clears the sticky flags
    BUSYWAIT = 1'b1;
    #3 RESET_N = 1'b0;
    #1;
    check("rst_stall_pc", PC_DATA, 32'h0);
    check("rst_stall_flags", {30'b0, RAS_OVF, RAS_UNF}, 32'h0);
    RESET_N = 1'b1;
    BUSYWAIT = 1'b0;
    step(3'd0); check("post_rst_seq", PC_DATA, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
